// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch front-end with an in-order
// response buffer feeding the IF/ID register. A taken branch redirects the
// fetch stream and discards everything buffered or still in flight.

// One queue slot: holds the fetch PC, the returned instruction and a filled
// flag. Allocation, fill and pop never target the same slot in one cycle.
module fq_slot (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        alloc_i,
  input  logic [63:0] alloc_pc_i,
  input  logic        fill_i,
  input  logic [31:0] fill_data_i,
  input  logic        pop_i,
  output logic [63:0] pc_o,
  output logic [31:0] instr_o,
  output logic        filled_o
);

  logic [63:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        filled_q, filled_d;

  // Slot next state; a clear (redirect) wins over any other update.
  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    filled_d = filled_q;
    if (clr_i) begin
      pc_d     = '0;
      instr_d  = '0;
      filled_d = 1'b0;
    end else begin
      if (alloc_i) begin
        pc_d     = alloc_pc_i;
        filled_d = 1'b0;
      end
      if (fill_i) begin
        instr_d  = fill_data_i;
        filled_d = 1'b1;
      end
      if (pop_i) begin
        filled_d = 1'b0;
      end
    end
  end

  // Slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= '0;
      instr_q  <= '0;
      filled_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      filled_q <= filled_d;
    end
  end

  assign pc_o     = pc_q;
  assign instr_o  = instr_q;
  assign filled_o = filled_q;

endmodule

module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] PC_RESET = 64'h0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     redirect,
  input  logic [63:0]              redirect_pc,
  output logic                     imem_req_valid,
  output logic [63:0]              imem_req_addr,
  input  logic                     imem_req_ready,
  input  logic                     imem_resp_valid,
  input  logic [31:0]              imem_resp_data,
  output logic                     out_valid,
  output logic [63:0]              out_pc,
  output logic [31:0]              out_instruction,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  logic [63:0] req_pc_q, req_pc_d;
  ptr_t        alloc_ptr_q, alloc_ptr_d;
  ptr_t        fill_ptr_q, fill_ptr_d;
  ptr_t        head_ptr_q, head_ptr_d;
  cnt_t        used_q, used_d;
  cnt_t        inflight_q, inflight_d;
  cnt_t        drop_q, drop_d;

  logic [DEPTH-1:0][63:0] slot_pc;
  logic [DEPTH-1:0][31:0] slot_instr;
  logic [DEPTH-1:0]       slot_filled;

  logic req_fire, resp_fire, resp_keep, out_fire, head_filled;

  // Low bits of the branch target are forced to zero, so they are never read.
  logic unused_rpc;
  assign unused_rpc = ^redirect_pc[1:0];

  // Request channel; held low while reset is asserted so nothing issues early.
  always_comb begin
    imem_req_valid = reset && !redirect && (used_q < DEPTH_C) && (inflight_q < DEPTH_C);
    imem_req_addr  = req_pc_q;
  end

  // Handshake decode and head presentation. The head view is zero whenever
  // the head slot is empty, so reset drives the data outputs to zero too.
  always_comb begin
    req_fire        = imem_req_valid && imem_req_ready;
    resp_fire       = imem_resp_valid;
    resp_keep       = resp_fire && !redirect && (drop_q == '0);
    head_filled     = slot_filled[head_ptr_q];
    out_valid       = !redirect && head_filled;
    out_pc          = head_filled ? slot_pc[head_ptr_q]    : 64'h0;
    out_instruction = head_filled ? slot_instr[head_ptr_q] : 32'h0;
    out_fire        = out_valid && out_ready;
    occupancy       = used_q;
  end

  // Pointer and counter next state. A redirect restarts everything and turns
  // every outstanding response, including one arriving now, into a drop.
  always_comb begin
    req_pc_d    = req_pc_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    used_d      = used_q;
    inflight_d  = inflight_q;
    drop_d      = drop_q;
    if (redirect) begin
      req_pc_d    = {redirect_pc[63:2], 2'b00};
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_ptr_d  = '0;
      used_d      = '0;
      inflight_d  = inflight_q - cnt_t'(resp_fire);
      drop_d      = inflight_q - cnt_t'(resp_fire);
    end else begin
      if (req_fire) begin
        req_pc_d    = req_pc_q + 64'd4;
        alloc_ptr_d = alloc_ptr_q + ptr_t'(1);
      end
      if (resp_fire) begin
        if (drop_q != '0) drop_d = drop_q - cnt_t'(1);
        else              fill_ptr_d = fill_ptr_q + ptr_t'(1);
      end
      if (out_fire) begin
        head_ptr_d = head_ptr_q + ptr_t'(1);
      end
      used_d     = used_q + cnt_t'(req_fire) - cnt_t'(out_fire);
      inflight_d = inflight_q + cnt_t'(req_fire) - cnt_t'(resp_fire);
    end
  end

  // Control state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_pc_q    <= PC_RESET;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      used_q      <= '0;
      inflight_q  <= '0;
      drop_q      <= '0;
    end else begin
      req_pc_q    <= req_pc_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      used_q      <= used_d;
      inflight_q  <= inflight_d;
      drop_q      <= drop_d;
    end
  end

  // Slot array; each slot decodes its own alloc/fill/pop strobes.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    fq_slot u_slot (
      .clk         (clock),
      .rst_n       (reset),
      .clr_i       (redirect),
      .alloc_i     (req_fire  && (alloc_ptr_q == ptr_t'(i))),
      .alloc_pc_i  (req_pc_q),
      .fill_i      (resp_keep && (fill_ptr_q  == ptr_t'(i))),
      .fill_data_i (imem_resp_data),
      .pop_i       (out_fire  && (head_ptr_q  == ptr_t'(i))),
      .pc_o        (slot_pc[i]),
      .instr_o     (slot_instr[i]),
      .filled_o    (slot_filled[i])
    );
  end

  // Structural invariants of the counters and the memory protocol.
  a_used_bound: assert property (@(posedge clock) disable iff (!reset)
    used_q <= DEPTH_C);
  a_inflight_bound: assert property (@(posedge clock) disable iff (!reset)
    inflight_q <= DEPTH_C);
  a_drop_le_inflight: assert property (@(posedge clock) disable iff (!reset)
    drop_q <= inflight_q);
  a_no_unsolicited_resp: assert property (@(posedge clock) disable iff (!reset)
    !(imem_resp_valid && (inflight_q == '0)));

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: random and directed stimulus; a memory model with in-order
// variable latency; a scoreboard of expected {pc, instruction} pairs checked
// by a monitor whenever the queue presents its head.
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [63:0] PCR   = 64'h1000;

  logic        clock, reset, redirect;
  logic [63:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready, imem_resp_valid;
  logic [63:0] imem_req_addr;
  logic [31:0] imem_resp_data;
  logic        out_valid, out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instruction;
  logic [2:0]  occupancy;

  fetch_queue #(.DEPTH(DEPTH), .PC_RESET(PCR)) dut (
    .clock(clock), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .out_valid(out_valid), .out_pc(out_pc),
    .out_instruction(out_instruction), .out_ready(out_ready), .occupancy(occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { logic [63:0] pc; logic [31:0] ins; } exp_t;
  typedef struct { logic [63:0] addr; int due; int ep; } pend_t;

  exp_t  sb[$];
  pend_t pend[$];

  int errors = 0, checks = 0;
  int cyc = 0, pops = 0, epoch = 0, resp_ep = 0, avail = 0;
  int lat_min = 1, lat_max = 1, rdy_pct = 100;
  logic [63:0] req_pc_m = PCR;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[33:2] * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory model plus monitor/scoreboard. Memory drives just after the rising
  // edge; the monitor samples on the falling edge and updates the reference.
  initial begin
    pend_t p;
    exp_t  e;
    int    infl;
    bit    e_rv, e_ov, fire_o;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(posedge clock);
      cyc++;
      #1;
      imem_req_ready = ($urandom_range(99) < rdy_pct);
      if (reset && pend.size() > 0 && pend[0].due <= cyc) begin
        p = pend.pop_front();
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(p.addr);
        resp_ep         = p.ep;
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
      end
      @(negedge clock);
      if (!reset) begin
        sb.delete();
        pend.delete();
        avail           = 0;
        req_pc_m        = PCR;
        imem_resp_valid = 1'b0;
      end else begin
        infl = pend.size() + (imem_resp_valid ? 1 : 0);
        e_rv = !redirect && sb.size() < DEPTH && infl < DEPTH;
        e_ov = !redirect && avail > 0;
        chk("req_valid", 64'(imem_req_valid), 64'(e_rv));
        chk("occupancy", 64'(occupancy), 64'(sb.size()));
        chk("out_valid", 64'(out_valid), 64'(e_ov));
        fire_o = out_valid && e_ov && sb.size() > 0;
        if (fire_o) begin
          chk("out_pc", out_pc, sb[0].pc);
          chk("out_instr", 64'(out_instruction), 64'(sb[0].ins));
        end
        if (redirect) begin
          sb.delete();
          avail    = 0;
          epoch++;
          req_pc_m = {redirect_pc[63:2], 2'b00};
        end else begin
          if (imem_resp_valid && resp_ep == epoch) avail++;
          if (fire_o && out_ready) begin
            void'(sb.pop_front());
            avail--;
            pops++;
          end
          if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, req_pc_m);
            e.pc  = req_pc_m;
            e.ins = mem_word(req_pc_m);
            sb.push_back(e);
            p.addr = req_pc_m;
            p.due  = cyc + $urandom_range(lat_max, lat_min);
            p.ep   = epoch;
            pend.push_back(p);
            req_pc_m = req_pc_m + 64'd4;
          end
        end
      end
    end
  end

  task automatic wait_out(input string nm, input logic [63:0] pc);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clock);
      if (out_valid) begin
        seen = 1;
        chk(nm, out_pc, pc);
      end
    end
    if (!seen) chk({nm, "_timeout"}, 64'(out_valid), 64'd1);
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_req_valid"}, 64'(imem_req_valid), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_pc"}, out_pc, 64'd0);
    chk({tag, "_out_instr"}, 64'(out_instruction), 64'd0);
    chk({tag, "_occupancy"}, 64'(occupancy), 64'd0);
  endtask

  // Hard stop if the run ever stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    #2 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 chk_zero_outs("reset");

    // Streaming, zero-wait memory.
    out_ready = 1'b1; reset = 1'b1;
    @(negedge clock);
    chk("first_req_valid", 64'(imem_req_valid), 64'd1);
    chk("first_req_addr", imem_req_addr, PCR);
    chk("first_out_valid_c0", 64'(out_valid), 64'd0);
    @(negedge clock); chk("first_out_valid_c1", 64'(out_valid), 64'd0);
    @(negedge clock);
    chk("first_out_valid_c2", 64'(out_valid), 64'd1);
    chk("first_out_pc", out_pc, PCR);
    @(posedge clock); p0 = pops;
    repeat (10) @(posedge clock);
    chk("sustained_rate", 64'(pops - p0), 64'd10);

    // Redirect coincident with a response and a would-be output.
    #1 redirect = 1'b1; redirect_pc = 64'h3000;
    @(negedge clock);
    chk("coinc_out_valid", 64'(out_valid), 64'd0);
    chk("coinc_req_valid", 64'(imem_req_valid), 64'd0);
    @(posedge clock); #1 redirect = 1'b0;
    @(negedge clock);
    chk("coinc_target_req", imem_req_addr, 64'h3000);
    @(negedge clock); chk("coinc_out_r2", 64'(out_valid), 64'd0);
    @(negedge clock);
    chk("coinc_out_r3", 64'(out_valid), 64'd1);
    chk("coinc_pc", out_pc, 64'h3000);
    chk("coinc_instr", 64'(out_instruction), 64'(mem_word(64'h3000)));

    // Stall until full, then drain.
    @(posedge clock); #1 reset = 1'b0; out_ready = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    repeat (10) @(negedge clock);
    chk("full_occupancy", 64'(occupancy), 64'd4);
    chk("full_req_valid", 64'(imem_req_valid), 64'd0);
    chk("full_head_pc", out_pc, PCR);
    @(posedge clock); #1 out_ready = 1'b1;
    @(negedge clock); chk("drain_pc0", out_pc, PCR);
    @(negedge clock); chk("drain_pc1", out_pc, PCR + 64'd4);

    // Redirect with several fetches in flight (latency 3).
    lat_min = 3; lat_max = 3;
    repeat (8) @(posedge clock);
    #1 redirect = 1'b1; redirect_pc = 64'h2003;
    @(negedge clock);
    chk("redir_out_valid", 64'(out_valid), 64'd0);
    @(posedge clock); #1 redirect = 1'b0;
    wait_out("redir_first_pc", 64'h2000);
    wait_out("redir_second_pc", 64'h2004);

    // Random backpressure, latency and redirects.
    lat_min = 1; lat_max = 4; rdy_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock); #1;
      out_ready   = 1'($urandom_range(1));
      redirect    = ($urandom_range(99) < 5);
      redirect_pc = {$urandom, $urandom};
    end
    @(posedge clock); #1 redirect = 1'b0;

    // Asynchronous reset between clock edges.
    repeat (3) @(posedge clock);
    #3 reset = 1'b0; rdy_pct = 100; lat_min = 1; lat_max = 1;
    #1 chk_zero_outs("async_reset");
    @(posedge clock); @(posedge clock);
    #1 reset = 1'b1; out_ready = 1'b1;
    @(negedge clock);
    chk("post_reset_req_valid", 64'(imem_req_valid), 64'd1);
    chk("post_reset_req_addr", imem_req_addr, PCR);

    lat_min = 1; lat_max = 4; rdy_pct = 50;
    for (int i = 0; i < 300; i++) begin
      @(posedge clock); #1;
      out_ready   = 1'($urandom_range(1));
      redirect    = ($urandom_range(99) < 5);
      redirect_pc = {$urandom, $urandom};
    end
    @(posedge clock); #1 redirect = 1'b0; out_ready = 1'b1;
    repeat (20) @(posedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
